// File: rtl/bsg_link_oddr_ser_phy_if.sv
// Link bundle for bsg_link_oddr_ser_phy: the parallel word handshake on one side,
// and the registered serialized slice, parity and forwarded clock on the other.
interface bsg_link_oddr_ser_phy_if #(
  parameter int width_p = 16,
  parameter int ratio_p = 2
);
  logic                       valid_i;
  logic [width_p*ratio_p-1:0] data_i;
  logic                       ready_o;
  logic                       valid_r_o;
  logic [width_p-1:0]         data_r_o;
  logic                       parity_r_o;
  logic                       clk_r_o;

  modport master (
    output valid_i, data_i,
    input  ready_o, valid_r_o, data_r_o, parity_r_o, clk_r_o
  );

  modport slave (
    input  valid_i, data_i,
    output ready_o, valid_r_o, data_r_o, parity_r_o, clk_r_o
  );
endinterface

// File: rtl/bsg_link_oddr_ser_phy.sv
// Word-to-slice serializer (LSB slice first) with registered outputs and a clk_i/2 forwarded clock.
// Optional registered even parity per slice: define BSG_LINK_ODDR_SER_PHY_PARITY_EN.
module bsg_link_oddr_ser_phy #(
  parameter int width_p = 16,
  parameter int ratio_p = 2
) (
  input logic                    clk_i,
  input logic                    reset_i,
  bsg_link_oddr_ser_phy_if.slave link
);
  localparam int cnt_w = $clog2(ratio_p);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(ratio_p - 1);

  logic [ratio_p-1:0][width_p-1:0] buf_r;
  logic                            full_r;
  logic [cnt_w-1:0]                cnt_r;
  logic                            accept;
  logic [width_p-1:0]              slice_n;

  // Ready on the last slice lets the next word follow with no idle slice.
  assign link.ready_o = ~full_r | (cnt_r == last_cnt);
  assign accept       = link.valid_i & link.ready_o;
  assign slice_n      = full_r ? buf_r[cnt_r] : '0;

  always_ff @(posedge clk_i) begin
    if (accept) buf_r <= link.data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_r <= 1'b0;
      cnt_r  <= '0;
    end else if (accept) begin
      full_r <= 1'b1;
      cnt_r  <= '0;
    end else if (full_r) begin
      if (cnt_r == last_cnt) begin
        full_r <= 1'b0;
        cnt_r  <= '0;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      link.data_r_o  <= '0;
      link.valid_r_o <= 1'b0;
    end else begin
      link.data_r_o  <= slice_n;
      link.valid_r_o <= full_r;
    end
  end

`ifdef BSG_LINK_ODDR_SER_PHY_PARITY_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) link.parity_r_o <= 1'b0;
    else         link.parity_r_o <= ^slice_n;
  end
`else
  assign link.parity_r_o = 1'b0;
`endif

  // Forwarded clock: falling-edge toggle keeps it centred on the posedge-launched data.
  always_ff @(negedge clk_i or posedge reset_i) begin
    if (reset_i) link.clk_r_o <= 1'b0;
    else         link.clk_r_o <= ~link.clk_r_o;
  end
endmodule
